sign_op_arbiter_ctrl: RTL and testbench

Two-port arbiter and sequencing controller for the shared sign-dependent operand unit (AR/BR/CR datapath). It accepts requests from two independent requesters, grants one at a time round-robin, and loads that requester's operands. It then runs the compare/execute sequence and returns the W-bit result, operation kind and requester ID over a ready/valid response channel. It sits between the two client engines and the single datapath instance, which it owns.

---
 rtl/sign_op_pkg.sv | 20 ++
 rtl/sign_op_datapath.sv | 63 ++++++
 rtl/sign_op_arbiter_ctrl.sv | 144 ++++++++++++++
 tb/tb_sign_op_arbiter_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sign_op_pkg.sv
// Shared types and constants for the sign-dependent operand unit and its
// arbiter/sequencing controller.
package sign_op_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  // Operation kind reported with each result.
  localparam logic [1:0] KIND_CLR = 2'b00;
  localparam logic [1:0] KIND_DIV = 2'b01;
  localparam logic [1:0] KIND_MUL = 2'b10;

  // Requester index (two requesters, one bit).
  typedef logic req_id_t;

endpackage : sign_op_pkg

// File: rtl/sign_op_datapath.sv
// AR/BR/CR datapath: operand registers, sign/zero classification of AR and
// the result register CR. The controls load/div/mul/clr are mutually
// exclusive and come from the controller FSM.
module sign_op_datapath
  import sign_op_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clock,
  input  logic                reset_b,
  input  logic                load,
  input  logic                div,
  input  logic                mul,
  input  logic                clr,
  input  logic signed [W-1:0] a_in,
  input  logic signed [W-1:0] b_in,
  output logic                ar_neg,
  output logic                ar_zero,
  output logic signed [W-1:0] cr
);

  logic signed [W-1:0] ar;
  logic signed [W-1:0] br;

  // Halving of a negative operand: arithmetic shift keeps the sign bit.
  function automatic logic signed [W-1:0] asr1(input logic signed [W-1:0] x);
    return x >>> 1;
  endfunction

  // Doubling with wrap: the MSB of the operand is deliberately dropped.
  function automatic logic signed [W-1:0] shl1_wrap(input logic signed [W-1:0] x);
    return {x[W-2:0], 1'b0};
  endfunction

  // Classification flags look at the registered AR only.
  assign ar_neg  = ar[W-1];
  assign ar_zero = (ar == '0);

  // Operand registers capture the granted requester's operands.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      ar <= '0;
      br <= '0;
    end else if (load) begin
      ar <= a_in;
      br <= b_in;
    end
  end

  // Result register written once per operation in the execute cycle.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      cr <= '0;
    end else if (div) begin
      cr <= asr1(ar);
    end else if (mul) begin
      cr <= shl1_wrap(br);
    end else if (clr) begin
      cr <= '0;
    end
  end

endmodule : sign_op_datapath

// File: rtl/sign_op_arbiter_ctrl.sv
// Two-port round-robin arbiter and sequencer for the shared sign-dependent
// operand unit. Grants one requester at a time, runs one execute cycle and
// hands the result out over a ready/valid channel.
module sign_op_arbiter_ctrl
  import sign_op_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_b,
  input  logic [1:0]   req,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic [1:0]   gnt,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [1:0]   rsp_kind,
  output logic [W-1:0] rsp_data,
  output logic         busy
);

  state_t              state_q;
  state_t              state_d;
  req_id_t             ptr_q;
  req_id_t             win;
  logic                load;
  logic                div;
  logic                mul;
  logic                clr;
  logic                ar_neg;
  logic                ar_zero;
  logic signed [W-1:0] a_sel;
  logic signed [W-1:0] b_sel;
  logic signed [W-1:0] cr;

  // Winner selection: a lone request always wins, a tie goes to the pointer.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = ptr_q;
    end else begin
      win = req[1];
    end
  end

  assign a_sel = win ? $signed(a1) : $signed(a0);
  assign b_sel = win ? $signed(b1) : $signed(b0);

  // Next-state, grant and datapath control decode.
  always_comb begin
    state_d = state_q;
    gnt     = 2'b00;
    load    = 1'b0;
    div     = 1'b0;
    mul     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          gnt     = win ? 2'b10 : 2'b01;
          load    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (ar_neg) begin
          div = 1'b1;
        end else if (ar_zero) begin
          clr = 1'b1;
        end else begin
          mul = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and round-robin pointer (pointer moves to the loser).
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        ptr_q <= ~win;
      end
    end
  end

  // Registered response sideband and status outputs.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_kind  <= KIND_CLR;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= (state_d == RESP);
      busy      <= (state_d != IDLE);
      if (load) begin
        rsp_id <= win;
      end
      if (div) begin
        rsp_kind <= KIND_DIV;
      end else if (mul) begin
        rsp_kind <= KIND_MUL;
      end else if (clr) begin
        rsp_kind <= KIND_CLR;
      end
    end
  end

  sign_op_datapath #(
    .W (W)
  ) u_datapath (
    .clock   (clock),
    .reset_b (reset_b),
    .load    (load),
    .div     (div),
    .mul     (mul),
    .clr     (clr),
    .a_in    (a_sel),
    .b_in    (b_sel),
    .ar_neg  (ar_neg),
    .ar_zero (ar_zero),
    .cr      (cr)
  );

  // CR is already a register; it doubles as the held response data.
  assign rsp_data = cr;

endmodule : sign_op_arbiter_ctrl

// File: tb/tb_sign_op_arbiter_ctrl.sv
// Self-checking bench for sign_op_arbiter_ctrl: directed scenarios followed
// by constrained-random traffic, all compared against a transaction model.
module tb_sign_op_arbiter_ctrl;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset_b;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [1:0]   rsp_kind;
  logic [W-1:0] rsp_data;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Model state: outstanding operation, cycles since grant, round-robin pointer,
  // and the values the response outputs should currently show.
  bit           m_has;
  int           m_age;
  bit           m_ptr;
  bit           m_id;
  logic [1:0]   m_kind;
  logic [W-1:0] m_data;
  logic [W-1:0] m_a, m_b;
  logic [1:0]   last_gnt;

  logic [W-1:0] oa[2];
  logic [W-1:0] ob[2];
  logic [1:0]   hold;

  sign_op_arbiter_ctrl #(.W(W)) dut (
    .clock     (clock),
    .reset_b   (reset_b),
    .req       (req),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_kind  (rsp_kind),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Result from the arithmetic meaning of the operation, not from bit shifts.
  task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] data, output logic [1:0] kind);
    int sa;
    int q;
    int p;
    sa = int'($signed(a));
    if (sa < 0) begin
      q    = (sa - ((sa % 2 != 0) ? 1 : 0)) / 2;  // floor(sa/2)
      data = q[W-1:0];
      kind = 2'b01;
    end else if (sa == 0) begin
      data = '0;
      kind = 2'b00;
    end else begin
      p    = int'(b) * 2;                         // wraps modulo 2**W
      data = p[W-1:0];
      kind = 2'b10;
    end
  endtask

  task automatic model_reset();
    m_has  = 0;
    m_age  = 0;
    m_ptr  = 0;
    m_id   = 0;
    m_kind = 2'b00;
    m_data = '0;
    last_gnt = 2'b00;
  endtask

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model across the coming rising edge.
  task automatic step(input logic [1:0] rq, input logic rdy,
                      input logic [W-1:0] va0, input logic [W-1:0] vb0,
                      input logic [W-1:0] va1, input logic [W-1:0] vb1);
    logic [1:0] exp_g;
    bit         w;
    exp_g = 2'b00;
    w     = 0;
    @(negedge clock);
    req = rq; rsp_ready = rdy; a0 = va0; b0 = vb0; a1 = va1; b1 = vb1;
    #1;
    if (!m_has && rq != 2'b00) begin
      w     = (rq == 2'b11) ? m_ptr : rq[1];
      exp_g = w ? 2'b10 : 2'b01;
    end
    check("gnt",       gnt,       exp_g);
    check("rsp_valid", rsp_valid, m_has && m_age >= 1);
    check("busy",      busy,      m_has);
    check("rsp_id",    rsp_id,    m_id);
    check("rsp_kind",  rsp_kind,  m_kind);
    check("rsp_data",  rsp_data,  m_data);
    last_gnt = gnt;
    if (exp_g != 2'b00) begin
      m_has = 1;
      m_age = 0;
      m_id  = w;
      m_ptr = !w;
      m_a   = w ? va1 : va0;
      m_b   = w ? vb1 : vb0;
    end else if (m_has) begin
      if (m_age == 0) begin
        ref_op(m_a, m_b, m_data, m_kind);
        m_age = 1;
      end else if (rdy) begin
        m_has = 0;
      end
    end
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear at once.
  task automatic do_reset();
    @(negedge clock);
    #2;
    req     = 2'b00;
    reset_b = 1'b0;
    #1;
    check("rst_gnt",       gnt,       2'b00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id",    rsp_id,    1'b0);
    check("rst_rsp_kind",  rsp_kind,  2'b00);
    check("rst_rsp_data",  rsp_data,  '0);
    check("rst_busy",      busy,      1'b0);
    model_reset();
    @(negedge clock);
    reset_b = 1'b1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 16'h0001;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      4:       return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    reset_b = 1'b0;
    req = 2'b00; rsp_ready = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    model_reset();
    #1;
    check("init_gnt",       gnt,       2'b00);
    check("init_rsp_valid", rsp_valid, 1'b0);
    check("init_busy",      busy,      1'b0);
    check("init_rsp_data",  rsp_data,  '0);
    @(negedge clock);
    reset_b = 1'b1;

    // Requester 0 alone, positive AR -> doubled BR.
    step(2'b01, 1'b1, 16'h00FF, 16'h0FFF, '0, '0);
    check("t1_gnt", last_gnt, 2'b01);
    step(2'b00, 1'b1, '0, '0, '0, '0);
    step(2'b00, 1'b1, '0, '0, '0, '0);
    check("t1_valid", rsp_valid, 1'b1);
    check("t1_data",  rsp_data,  16'h1FFE);
    check("t1_kind",  rsp_kind,  2'b10);
    check("t1_id",    rsp_id,    1'b0);

    // Requester 1: negative AR halves, then zero AR clears.
    step(2'b10, 1'b1, '0, '0, 16'h8FFF, 16'h0000);
    step(2'b00, 1'b1, '0, '0, '0, '0);
    step(2'b00, 1'b1, '0, '0, '0, '0);
    check("t2_data", rsp_data, 16'hC7FF);
    check("t2_kind", rsp_kind, 2'b01);
    check("t2_id",   rsp_id,   1'b1);
    step(2'b10, 1'b1, '0, '0, 16'h0000, 16'h1234);
    step(2'b00, 1'b1, '0, '0, '0, '0);
    step(2'b00, 1'b1, '0, '0, '0, '0);
    check("t3_data", rsp_data, 16'h0000);
    check("t3_kind", rsp_kind, 2'b00);

    // Both requesting continuously from reset: grants alternate 01,10,01.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(2'b11, 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0007);
      if (k % 3 == 0) check("rr_gnt", last_gnt, (k % 6 == 0) ? 2'b01 : 2'b10);
    end

    // Backpressure: result held while req[1] waits, then granted right after.
    do_reset();
    step(2'b01, 1'b0, 16'h0001, 16'h8001, '0, '0);
    step(2'b10, 1'b0, '0, '0, 16'h0100, 16'h0002);
    for (int k = 0; k < 5; k++) begin
      step(2'b10, 1'b0, '0, '0, 16'h0100, 16'h0002);
      check("bp_data",  rsp_data,  16'h0002);
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_nognt", last_gnt,  2'b00);
    end
    step(2'b10, 1'b1, '0, '0, 16'h0100, 16'h0002);
    step(2'b10, 1'b1, '0, '0, 16'h0100, 16'h0002);
    check("bp_gnt_after", last_gnt, 2'b10);
    step(2'b00, 1'b1, '0, '0, '0, '0);
    step(2'b00, 1'b1, '0, '0, '0, '0);

    // Reset during EXEC discards the operation; pointer back to 0.
    step(2'b01, 1'b1, 16'h0005, 16'h0006, '0, '0);
    do_reset();
    step(2'b00, 1'b1, '0, '0, '0, '0);
    step(2'b00, 1'b1, '0, '0, '0, '0);
    step(2'b11, 1'b1, 16'h0004, 16'h0004, 16'h0009, 16'h0009);
    check("post_rst_gnt", last_gnt, 2'b01);
    step(2'b10, 1'b1, '0, '0, 16'h0009, 16'h0009);
    step(2'b10, 1'b1, '0, '0, 16'h0009, 16'h0009);
    step(2'b10, 1'b1, '0, '0, 16'h0009, 16'h0009);
    step(2'b00, 1'b1, '0, '0, '0, '0);
    step(2'b00, 1'b1, '0, '0, '0, '0);

    // Random traffic: requests held with stable operands until granted.
    hold = 2'b00;
    for (int i = 0; i < 2; i++) begin
      oa[i] = '0;
      ob[i] = '0;
    end
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        hold = 2'b00;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (!hold[i] && $urandom_range(0, 2) == 0) begin
            hold[i] = 1'b1;
            oa[i]   = pick();
            ob[i]   = pick();
          end
        end
        step(hold, ($urandom_range(0, 3) != 0), oa[0], ob[0], oa[1], ob[1]);
        for (int i = 0; i < 2; i++) begin
          if (last_gnt[i]) begin
            hold[i] = 1'($urandom_range(0, 1));
            if (hold[i]) begin
              oa[i] = pick();
              ob[i] = pick();
            end
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sign_op_arbiter_ctrl
